// File: rtl/gl_tri_setup_pkg.sv
// gl_tri_setup_pkg: state encodings and float32 field layout shared by triangle setup
package gl_tri_setup_pkg;

    typedef enum logic [1:0] {
        GL_TS_COLLECT = 2'd0,
        GL_TS_AREA    = 2'd1,
        GL_TS_CLIP    = 2'd2,
        GL_TS_EMIT    = 2'd3
    } ts_state_t;

    localparam int FP_SIGN     = 31;
    localparam int FP_EXP_HI   = 30;
    localparam int FP_EXP_LO   = 23;
    localparam int FP_MAN_HI   = 22;
    localparam int FP_MAN_W    = 23;
    localparam int FP_EXP_BIAS = 127;

endpackage

// File: rtl/gl_fp_to_fix.sv
// gl_fp_to_fix: combinational float32 -> unsigned COORD_W pixel coordinate, truncating and clamping
module gl_fp_to_fix
    import gl_tri_setup_pkg::*;
#(
    parameter int COORD_W = 11
) (
    input  logic [31:0]        i_f,
    output logic [COORD_W-1:0] o_fix
);

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [23:0] w_sig;
    logic [7:0]  w_sh;

    assign w_sign = i_f[FP_SIGN];
    assign w_exp  = i_f[FP_EXP_HI:FP_EXP_LO];
    assign w_man  = i_f[FP_MAN_HI:0];
    assign w_sig  = {1'b1, w_man};
    // Right shift that drops the fraction bits; only used when 1 <= value < 2^COORD_W
    assign w_sh   = 8'(FP_EXP_BIAS + FP_MAN_W) - w_exp;

    // NaN/negative/zero/denormal/<1 give 0, +inf and large magnitudes saturate
    assign o_fix = (w_exp == 8'hFF) ? ((w_man == '0 && !w_sign) ? '1 : '0)
                 : (w_sign || w_exp < 8'(FP_EXP_BIAS)) ? '0
                 : (w_exp >= 8'(FP_EXP_BIAS + COORD_W)) ? '1
                 : COORD_W'(w_sig >> w_sh);

endmodule

// File: rtl/gl_tri_setup.sv
// gl_tri_setup: groups vertices into triangles, computes area and clipped bbox, culls and emits
// Optional: define GL_CULL_BACKFACE_EN to also cull negative-area (clockwise) triangles.
module gl_tri_setup
    import gl_tri_setup_pkg::*;
#(
    parameter int COORD_W    = 11,
    parameter int DROP_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vert_valid,
    output logic                      vert_ready,
    input  logic [95:0]               vert_in,
    input  logic [95:0]               color_in,
    input  logic [COORD_W-1:0]        vp_min_x,
    input  logic [COORD_W-1:0]        vp_min_y,
    input  logic [COORD_W-1:0]        vp_max_x,
    input  logic [COORD_W-1:0]        vp_max_y,
    output logic                      tri_valid,
    input  logic                      tri_ready,
    output logic [COORD_W-1:0]        tri_x0,
    output logic [COORD_W-1:0]        tri_y0,
    output logic [COORD_W-1:0]        tri_x1,
    output logic [COORD_W-1:0]        tri_y1,
    output logic [COORD_W-1:0]        tri_x2,
    output logic [COORD_W-1:0]        tri_y2,
    output logic [COORD_W-1:0]        tri_bb_min_x,
    output logic [COORD_W-1:0]        tri_bb_min_y,
    output logic [COORD_W-1:0]        tri_bb_max_x,
    output logic [COORD_W-1:0]        tri_bb_max_y,
    output logic [2*COORD_W+1:0]      tri_area,
    output logic [95:0]               tri_color,
    output logic [DROP_CNT_W-1:0]     drop_count
);

    localparam int AW = 2*COORD_W+2;

    ts_state_t               r_state, w_next;
    logic [1:0]              r_idx;
    logic [COORD_W-1:0]      r_x [3];
    logic [COORD_W-1:0]      r_y [3];
    logic [95:0]             r_color;
    logic signed [AW-1:0]    r_area;
    logic [COORD_W-1:0]      r_rmin_x, r_rmin_y, r_rmax_x, r_rmax_y;
    logic [COORD_W-1:0]      w_fx, w_fy;
    logic [COORD_W-1:0]      w_min_x, w_min_y, w_max_x, w_max_y;
    logic [COORD_W-1:0]      w_bb_min_x, w_bb_min_y, w_bb_max_x, w_bb_max_y;
    logic signed [AW-1:0]    w_dx1, w_dy1, w_dx2, w_dy2, w_area;
    logic                    w_accept, w_cull, w_drop;
    logic                    w_unused_z;

    gl_fp_to_fix #(.COORD_W(COORD_W)) u_fx (.i_f(vert_in[95:64]), .o_fix(w_fx));
    gl_fp_to_fix #(.COORD_W(COORD_W)) u_fy (.i_f(vert_in[63:32]), .o_fix(w_fy));

    // Depth is carried on the bus but not needed for setup
    assign w_unused_z = ^vert_in[31:0];

    assign vert_ready = (r_state == GL_TS_COLLECT) && !reset;
    assign tri_valid  = (r_state == GL_TS_EMIT);
    assign w_accept   = vert_valid && vert_ready;

    // Edge-function area; true result always fits AW bits, so wrapping intermediates are harmless
    always_comb begin
        w_dx1  = AW'(r_x[1]) - AW'(r_x[0]);
        w_dy1  = AW'(r_y[1]) - AW'(r_y[0]);
        w_dx2  = AW'(r_x[2]) - AW'(r_x[0]);
        w_dy2  = AW'(r_y[2]) - AW'(r_y[0]);
        w_area = w_dx1 * w_dy2 - w_dx2 * w_dy1;
    end

    // Unclipped bounding box of the three collected vertices
    always_comb begin
        w_min_x = (r_x[0] < r_x[1]) ? r_x[0] : r_x[1];
        w_min_x = (r_x[2] < w_min_x) ? r_x[2] : w_min_x;
        w_max_x = (r_x[0] > r_x[1]) ? r_x[0] : r_x[1];
        w_max_x = (r_x[2] > w_max_x) ? r_x[2] : w_max_x;
        w_min_y = (r_y[0] < r_y[1]) ? r_y[0] : r_y[1];
        w_min_y = (r_y[2] < w_min_y) ? r_y[2] : w_min_y;
        w_max_y = (r_y[0] > r_y[1]) ? r_y[0] : r_y[1];
        w_max_y = (r_y[2] > w_max_y) ? r_y[2] : w_max_y;
    end

    assign w_bb_min_x = (r_rmin_x > vp_min_x) ? r_rmin_x : vp_min_x;
    assign w_bb_min_y = (r_rmin_y > vp_min_y) ? r_rmin_y : vp_min_y;
    assign w_bb_max_x = (r_rmax_x < vp_max_x) ? r_rmax_x : vp_max_x;
    assign w_bb_max_y = (r_rmax_y < vp_max_y) ? r_rmax_y : vp_max_y;

`ifdef GL_CULL_BACKFACE_EN
    assign w_cull = r_area[AW-1];
`else
    assign w_cull = 1'b0;
`endif

    assign w_drop = (r_area == '0) || (w_bb_min_x > w_bb_max_x) || (w_bb_min_y > w_bb_max_y) || w_cull;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= GL_TS_COLLECT;
        else       r_state <= w_next;
    end

    // Next state: collect three vertices, then one cycle each for area and clip, then hold until taken
    always_comb begin
        w_next = r_state;
        w_next = (r_state == GL_TS_COLLECT) ? ((w_accept && r_idx == 2'd2) ? GL_TS_AREA : GL_TS_COLLECT)
               : (r_state == GL_TS_AREA)    ? GL_TS_CLIP
               : (r_state == GL_TS_CLIP)    ? (w_drop ? GL_TS_COLLECT : GL_TS_EMIT)
               : (tri_ready ? GL_TS_COLLECT : GL_TS_EMIT);
    end

    // Datapath: vertex slots, area/bbox registers, output registers and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_x          <= '{default: '0};
            r_y          <= '{default: '0};
            r_color      <= '0;
            r_area       <= '0;
            r_rmin_x     <= '0;
            r_rmin_y     <= '0;
            r_rmax_x     <= '0;
            r_rmax_y     <= '0;
            tri_x0       <= '0;
            tri_y0       <= '0;
            tri_x1       <= '0;
            tri_y1       <= '0;
            tri_x2       <= '0;
            tri_y2       <= '0;
            tri_bb_min_x <= '0;
            tri_bb_min_y <= '0;
            tri_bb_max_x <= '0;
            tri_bb_max_y <= '0;
            tri_area     <= '0;
            tri_color    <= '0;
            drop_count   <= '0;
        end else begin
            if (w_accept) begin
                r_x[r_idx] <= w_fx;
                r_y[r_idx] <= w_fy;
                r_idx      <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
                if (r_idx == 2'd2) r_color <= color_in;
            end
            if (r_state == GL_TS_AREA) begin
                r_area   <= w_area;
                r_rmin_x <= w_min_x;
                r_rmin_y <= w_min_y;
                r_rmax_x <= w_max_x;
                r_rmax_y <= w_max_y;
            end
            if (r_state == GL_TS_CLIP) begin
                if (w_drop) begin
                    if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
                end else begin
                    tri_x0       <= r_x[0];
                    tri_y0       <= r_y[0];
                    tri_x1       <= r_x[1];
                    tri_y1       <= r_y[1];
                    tri_x2       <= r_x[2];
                    tri_y2       <= r_y[2];
                    tri_bb_min_x <= w_bb_min_x;
                    tri_bb_min_y <= w_bb_min_y;
                    tri_bb_max_x <= w_bb_max_x;
                    tri_bb_max_y <= w_bb_max_y;
                    tri_area     <= r_area;
                    tri_color    <= r_color;
                end
            end
        end
    end

endmodule

// File: tb/tb_gl_tri_setup.sv
// tb_gl_tri_setup: scoreboard bench for gl_tri_setup with a real-arithmetic reference model
module tb_gl_tri_setup;

    localparam int CW = 11;
    localparam int AW = 2*CW+2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vert_valid = 1'b0;
    logic          vert_ready;
    logic [95:0]   vert_in = '0;
    logic [95:0]   color_in = '0;
    logic [CW-1:0] vp_min_x = '0, vp_min_y = '0, vp_max_x = '0, vp_max_y = '0;
    logic          tri_valid;
    logic          tri_ready = 1'b0;
    logic [CW-1:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
    logic [CW-1:0] tri_bb_min_x, tri_bb_min_y, tri_bb_max_x, tri_bb_max_y;
    logic [AW-1:0] tri_area;
    logic [95:0]   tri_color;
    logic [15:0]   drop_count;

    logic          s_vert_ready, s_tri_valid;
    logic [CW-1:0] s_x0, s_y0, s_x1, s_y1, s_x2, s_y2, s_bx0, s_by0, s_bx1, s_by1;
    logic [AW-1:0] s_area;
    logic [95:0]   s_color;
    logic [2:0]    s_drop_count;

    gl_tri_setup #(.COORD_W(CW), .DROP_CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .vert_valid(vert_valid), .vert_ready(vert_ready),
        .vert_in(vert_in), .color_in(color_in),
        .vp_min_x(vp_min_x), .vp_min_y(vp_min_y), .vp_max_x(vp_max_x), .vp_max_y(vp_max_y),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1), .tri_x2(tri_x2), .tri_y2(tri_y2),
        .tri_bb_min_x(tri_bb_min_x), .tri_bb_min_y(tri_bb_min_y),
        .tri_bb_max_x(tri_bb_max_x), .tri_bb_max_y(tri_bb_max_y),
        .tri_area(tri_area), .tri_color(tri_color), .drop_count(drop_count)
    );

    // Narrow-counter twin fed by the same stream, used to observe counter saturation cheaply
    gl_tri_setup #(.COORD_W(CW), .DROP_CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .vert_valid(vert_valid), .vert_ready(s_vert_ready),
        .vert_in(vert_in), .color_in(color_in),
        .vp_min_x(vp_min_x), .vp_min_y(vp_min_y), .vp_max_x(vp_max_x), .vp_max_y(vp_max_y),
        .tri_valid(s_tri_valid), .tri_ready(tri_ready),
        .tri_x0(s_x0), .tri_y0(s_y0), .tri_x1(s_x1), .tri_y1(s_y1), .tri_x2(s_x2), .tri_y2(s_y2),
        .tri_bb_min_x(s_bx0), .tri_bb_min_y(s_by0), .tri_bb_max_x(s_bx1), .tri_bb_max_y(s_by1),
        .tri_area(s_area), .tri_color(s_color), .drop_count(s_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x0, y0, x1, y1, x2, y2;
        int          bminx, bminy, bmaxx, bmaxy;
        longint      area;
        logic [95:0] col;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs = 0;
    int   drops = 0;
    int   px[3], py[3];
    int   pn = 0;
    bit   rnd_ready = 0;
    bit   fixed_ready = 0;

    localparam logic [31:0] F10 = 32'h41200000, F20 = 32'h41A00000, F30 = 32'h41F00000;
    localparam logic [31:0] F100 = 32'h42C80000, F200 = 32'h43480000;
    localparam logic [31:0] FM5 = 32'hC0A00000, F5000 = 32'h459C4000, F7_9 = 32'h40FCCCCD;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Value of a float32 via real arithmetic, then the pixel mapping rules
    function automatic int to_fix(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (e == 255) return (f[22:0] == 0 && !f[31]) ? CMAX : 0;
        if (f[31] || e == 0) return 0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = e - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        if (v >= real'(CMAX + 1)) return CMAX;
        return $rtoi(v);
    endfunction

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    task automatic model_vert(input logic [31:0] fx, input logic [31:0] fy, input logic [95:0] col);
        exp_t e;
        px[pn] = to_fix(fx);
        py[pn] = to_fix(fy);
        pn++;
        if (pn == 3) begin
            pn = 0;
            e.x0 = px[0]; e.y0 = py[0]; e.x1 = px[1]; e.y1 = py[1]; e.x2 = px[2]; e.y2 = py[2];
            e.area = longint'(px[1] - px[0]) * longint'(py[2] - py[0]) - longint'(px[2] - px[0]) * longint'(py[1] - py[0]);
            e.bminx = imax(imin(imin(px[0], px[1]), px[2]), int'(vp_min_x));
            e.bminy = imax(imin(imin(py[0], py[1]), py[2]), int'(vp_min_y));
            e.bmaxx = imin(imax(imax(px[0], px[1]), px[2]), int'(vp_max_x));
            e.bmaxy = imin(imax(imax(py[0], py[1]), py[2]), int'(vp_max_y));
            e.col = col;
            if (e.area == 0 || e.bminx > e.bmaxx || e.bminy > e.bmaxy
`ifdef GL_CULL_BACKFACE_EN
                || e.area < 0
`endif
            ) drops++;
            else q.push_back(e);
        end
    endtask

    task automatic send_vert(input logic [31:0] fx, input logic [31:0] fy, input logic [95:0] col);
        int n = 0;
        vert_in = {fx, fy, 32'h3F800000};
        color_in = col;
        vert_valid = 1'b1;
        @(negedge clk);
        while (!vert_ready && n < 300) begin @(negedge clk); n++; end
        if (!vert_ready) begin
            checks++; errors++;
            $display("FAIL vert_accept_timeout: vert_ready stuck at 0 after %0d cycles", n);
            vert_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        vert_valid = 1'b0;
        model_vert(fx, fy, col);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || !vert_ready) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d triangles still expected, vert_ready=%0b", q.size(), vert_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_vp(input int x0, input int y0, input int x1, input int y1);
        vp_min_x = CW'(x0); vp_min_y = CW'(y0); vp_max_x = CW'(x1); vp_max_y = CW'(y1);
    endtask

    function automatic logic [31:0] rnd_float();
        int r;
        logic [31:0] sp [5];
        sp = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000000};
        r = $urandom_range(0, 99);
        if (r < 6) return sp[$urandom_range(0, 4)];
        if (r < 12) return {1'b1, 8'($urandom_range(120, 140)), 23'($urandom)};
        if (r < 18) return {1'b0, 8'($urandom_range(137, 150)), 23'($urandom)};
        return {1'b0, 8'($urandom_range(126, 136)), 23'($urandom)};
    endfunction

    task automatic check_drops(input string name);
        chk({name, "_drop_count"}, longint'(drop_count), longint'(drops > 65535 ? 65535 : drops));
        chk({name, "_sat_drop_count"}, longint'(s_drop_count), longint'(drops > 7 ? 7 : drops));
    endtask

    // Ready driver: applied after any same-edge stimulus update
    initial forever begin
        @(posedge clk); #2;
        tri_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // Scoreboard monitor: every cycle a triangle is presented it must match the queue head
    always @(negedge clk) begin
        if (!reset && tri_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL tri_unexpected: tri_valid with nothing expected, area=%0d", $signed(tri_area));
            end else if ({tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_bb_min_x, tri_bb_min_y,
                          tri_bb_max_x, tri_bb_max_y, tri_area, tri_color} !==
                         {CW'(q[0].x0), CW'(q[0].y0), CW'(q[0].x1), CW'(q[0].y1), CW'(q[0].x2), CW'(q[0].y2),
                          CW'(q[0].bminx), CW'(q[0].bminy), CW'(q[0].bmaxx), CW'(q[0].bmaxy),
                          AW'(q[0].area), q[0].col}) begin
                errors++;
                $display("FAIL tri_fields: got v=(%0d,%0d)(%0d,%0d)(%0d,%0d) bb=%0d..%0d x %0d..%0d area=%0d col=%h expected v=(%0d,%0d)(%0d,%0d)(%0d,%0d) bb=%0d..%0d x %0d..%0d area=%0d col=%h",
                         tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2, tri_bb_min_x, tri_bb_max_x,
                         tri_bb_min_y, tri_bb_max_y, $signed(tri_area), tri_color,
                         q[0].x0, q[0].y0, q[0].x1, q[0].y1, q[0].x2, q[0].y2, q[0].bminx, q[0].bmaxx,
                         q[0].bminy, q[0].bmaxy, q[0].area, q[0].col);
            end
            if (tri_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                hs++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, hs0;
        logic [95:0] c0, c1, c2;
        c0 = 96'h111111112222222233333333;
        c1 = 96'h444444445555555566666666;
        c2 = 96'h7777777788888888AAAAAAAA;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vert_ready", vert_ready, 0);
        chk("reset_tri_valid", tri_valid, 0);
        chk("reset_drop_count", drop_count, 0);
        chk("reset_tri_area", tri_area, 0);
        chk("reset_tri_color_nonzero", (tri_color != 0 || tri_x0 != 0 || tri_bb_max_y != 0), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("vert_ready_after_reset", vert_ready, 1);
        @(posedge clk); #1;

        // Basic triangle with latency check
        set_vp(0, 0, 639, 479);
        send_vert(F10, F10, c0);
        send_vert(F30, F10, c1);
        send_vert(F10, F30, c2);
        chk("latency_T", tri_valid, 0);
        @(posedge clk); #1;
        chk("latency_T1", tri_valid, 0);
        @(posedge clk); #1;
        chk("latency_T2", tri_valid, 1);
        chk("tri1_area", longint'($signed(tri_area)), 400);
        chk("tri1_color", longint'(tri_color == c2), 1);
        chk("tri1_bb", {tri_bb_min_x, tri_bb_max_x, tri_bb_min_y, tri_bb_max_y}, {11'd10, 11'd30, 11'd10, 11'd30});
        fixed_ready = 1;
        drain();

        // Reversed winding
        send_vert(F10, F10, c0);
        send_vert(F10, F30, c1);
        send_vert(F30, F10, c2);
        drain();
        check_drops("backface");

        // Collinear
        send_vert(F10, F10, c0);
        send_vert(F20, F20, c1);
        send_vert(F30, F30, c2);
        drain();
        check_drops("collinear");

        // Conversion corner cases
        set_vp(0, 0, CMAX, CMAX);
        fixed_ready = 0;
        send_vert(FM5, F7_9, c0);
        send_vert(F5000, F7_9, c1);
        send_vert(F7_9, F5000, c2);
        n = 0;
        @(negedge clk);
        while (!tri_valid && n < 20) begin @(negedge clk); n++; end
        chk("conv_neg5", tri_x0, 0);
        chk("conv_5000", tri_x1, CMAX);
        chk("conv_7_9", tri_y0, 7);
        @(posedge clk); #1;
        fixed_ready = 1;
        drain();

        // Fully outside a small viewport
        set_vp(0, 0, 15, 15);
        send_vert(F100, F100, c0);
        send_vert(F200, F100, c1);
        send_vert(F100, F200, c2);
        drain();
        check_drops("offscreen");

        // Long stall in EMIT with a vertex waiting
        set_vp(0, 0, 639, 479);
        fixed_ready = 0;
        send_vert(F10, F10, c0);
        send_vert(F30, F10, c1);
        send_vert(F10, F30, c2);
        vert_in = {F20, F10, 32'h0};
        color_in = c1;
        vert_valid = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_vert_ready", vert_ready, 0);
        end
        @(posedge clk); #1;
        hs0 = hs;
        fixed_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_one_handshake", hs - hs0, 1);
        chk("stall_valid_dropped", tri_valid, 0);
        chk("stall_next_ready", vert_ready, 1);
        @(posedge clk); #1;
        vert_valid = 1'b0;
        model_vert(F20, F10, c1);
        send_vert(F30, F30, c2);
        send_vert(F10, F30, c0);
        drain();

        // Reset with a partial triangle
        send_vert(F100, F100, c0);
        send_vert(F200, F100, c1);
        reset = 1'b1;
        pn = 0;
        drops = 0;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        send_vert(F10, F10, c0);
        send_vert(F30, F10, c1);
        send_vert(F10, F30, c2);
        drain();
        check_drops("after_reset");

        // Enough drops to saturate the narrow twin
        for (int i = 0; i < 10; i++) begin
            send_vert(F10, F10, c0);
            send_vert(F20, F20, c1);
            send_vert(F30, F30, c2);
        end
        drain();
        check_drops("saturate");

        // Randomised triangles and backpressure
        rnd_ready = 1;
        for (int t = 0; t < 80; t++) begin
            n = 0;
            @(negedge clk);
            while (!vert_ready && n < 50) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            set_vp($urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(150, CMAX), $urandom_range(150, CMAX));
            for (int v = 0; v < 3; v++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_vert(rnd_float(), rnd_float(), {32'($urandom), 32'($urandom), 32'($urandom)});
            end
        end
        drain();
        check_drops("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
